butterfly_seq_ctrl: RTL and testbench
=====================================

Name: butterfly_seq_ctrl

Overview:
- Parametrised successor to the single-butterfly switch-stepped controller.
- Walks the operator through NUM_LOADS operand-load steps, each gated by a debounced low-then-high toggle of ReadyIn.
- Runs a multi-cycle compute window, then steps through NUM_DISP result display pages.
- Drives one-hot load and display enables into the butterfly datapath and 7-segment mux.

Parameters:
NUM_LOADS, 3, number of operand load steps (e.g. W, Re b, Im b); range 1..16
NUM_DISP, 2, number of result display pages (e.g. W_RE, W_IM); range 1..16
COMPUTE_CYCLES, 1, cycles compute is held high; range 1..255
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles before ready_db changes; range 1..2^20

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
ReadyIn  input  1  raw slide switch, asynchronous to Clock
Clear  input  1  synchronous abort; returns FSM to IDLE
load_en  output  NUM_LOADS  one-hot, 1-cycle pulse: capture operand [step]
load_idx  output  max(1,$clog2(NUM_LOADS))  current load step index
compute  output  1  high for exactly COMPUTE_CYCLES cycles
disp_en  output  NUM_DISP  one-hot level: display page [page]
ready_db  output  1  debounced ReadyIn
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse after the last page is released

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, step=0, page=0, counters=0, sync flops=0, ready_db=0.
- Reset values of all outputs: load_en=0, disp_en=0, compute=0, done=0, busy=0, load_idx=0.
- Synchroniser: ReadyIn passes through 2 flops to give sync.
- Debounce: if sync!=ready_db, increment cnt; when cnt==DEBOUNCE_CYCLES-1 and sync still differs, toggle ready_db and clear cnt.
- Debounce: any cycle with sync==ready_db clears cnt, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Debounce latency: a clean input edge appears on ready_db 2+DEBOUNCE_CYCLES clocks later.
- FSM, evaluated on ready_db only:
  IDLE: step=0, page=0; next cycle -> WAIT_LO.
  WAIT_LO: if ready_db==0 -> WAIT_HI.
  WAIT_HI: if ready_db==1 -> LOAD.
  LOAD (1 cycle): load_en[step]=1. If step==NUM_LOADS-1 -> COMPUTE with ccnt=0; else step++ and -> WAIT_LO.
  COMPUTE: compute=1; ccnt++; when ccnt==COMPUTE_CYCLES-1 -> DISP_LO.
  DISP_LO: if ready_db==0 -> DISP_HI.
  DISP_HI: if ready_db==1 -> DISP.
  DISP: disp_en[page]=1 (level). On ready_db==0: if page==NUM_DISP-1 -> DONE, else page++ and -> DISP_HI.
  DONE (1 cycle): done=1; -> IDLE.
  Illegal encodings -> IDLE.
- Switch already high when a wait begins: must still see a low before a high; a held-high switch never double-loads.
- load_idx=step in all states; load_en is Moore-decoded from LOAD and glitch-free.
- Clear=1 in any state: next state IDLE, step/page cleared.
- Clear=1 in LOAD or DONE: load_en/done still asserted that cycle (Moore outputs); no further effect.
- Clear does not touch the debounce path.
- Reset mid-operation: immediate return to reset values; no partial-step memory.
- NUM_LOADS=1 or NUM_DISP=1 must elaborate; index widths are at least 1 bit.

Test Plan:
- Reset check (defaults): hold Reset 3 cycles -> all outputs 0, FSM reaches WAIT_LO 1 cycle after release, busy=1 from then on.
- Debounce (DEBOUNCE_CYCLES=4): ReadyIn high for 3 cycles then low -> ready_db stays 0. ReadyIn high held -> ready_db=1 exactly 6 cycles after the edge.
- Full run (NUM_LOADS=3, COMPUTE_CYCLES=2, NUM_DISP=2): toggle low/high 3 times.
  -> load_en pulses 001, 010, 100 with load_idx 0, 1, 2.
  -> compute high for 2 cycles.
  -> two more toggles show disp_en 01 then 10; final low gives done pulse, then busy=0 for 1 cycle (IDLE).
- Held switch: ReadyIn held high for 100 cycles after the first load -> exactly one load_en pulse; the second load occurs only after a low/high toggle.
- Abort: Clear pulsed while in WAIT_HI at step 1 -> IDLE next cycle; the next toggle produces load_en=001.
- Async reset in COMPUTE: Reset asserted mid-cycle -> compute drops before the next clock edge; no done pulse.

Source files
------------

// File: rtl/butterfly_seq_ctrl_if.sv
// Operator-facing handshake bundle for the butterfly sequence controller:
// switch/abort inputs plus the load, compute and display enables.
interface butterfly_seq_ctrl_if #(
    parameter int unsigned NUM_LOADS = 3,
    parameter int unsigned NUM_DISP  = 2
);
    localparam int unsigned IDX_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;

    logic                 ReadyIn;
    logic                 Clear;
    logic [NUM_LOADS-1:0] load_en;
    logic [IDX_W-1:0]     load_idx;
    logic                 compute;
    logic [NUM_DISP-1:0]  disp_en;
    logic                 ready_db;
    logic                 busy;
    logic                 done;

    modport master (
        output ReadyIn, Clear,
        input  load_en, load_idx, compute, disp_en, ready_db, busy, done
    );

    modport slave (
        input  ReadyIn, Clear,
        output load_en, load_idx, compute, disp_en, ready_db, busy, done
    );
endinterface

// File: rtl/butterfly_seq_ctrl.sv
// Switch-stepped butterfly controller: debounced ReadyIn toggles walk through
// NUM_LOADS operand loads, a fixed compute window and NUM_DISP display pages.
module butterfly_seq_ctrl #(
    parameter int unsigned NUM_LOADS       = 3,
    parameter int unsigned NUM_DISP        = 2,
    parameter int unsigned COMPUTE_CYCLES  = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                Clock,
    input logic                Reset,
    butterfly_seq_ctrl_if.slave bus
);
    localparam int unsigned STEP_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
    localparam int unsigned PAGE_W = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CC_W   = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_LO, S_WAIT_HI, S_LOAD, S_COMPUTE,
        S_DISP_LO, S_DISP_HI, S_DISP, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [CC_W-1:0]     ccnt_q, ccnt_d;
    logic                sync1_q, sync2_q;
    logic                db_q, db_d;
    logic [DB_W-1:0]     dbcnt_q, dbcnt_d;
    logic [NUM_LOADS-1:0] load_en_q, load_en_d;
    logic [NUM_DISP-1:0] disp_en_q, disp_en_d;
    logic                compute_q, compute_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Debounce: ready_db flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_d    = db_q;
        dbcnt_d = '0;
        if (sync2_q != db_q) begin
            if (dbcnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                dbcnt_d = dbcnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            dbcnt_q <= '0;
        end else begin
            sync1_q <= bus.ReadyIn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dbcnt_q <= dbcnt_d;
        end
    end

    // Next-state logic; every wait needs a low before a high so a held switch never double-steps.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        page_d  = page_q;
        ccnt_d  = ccnt_q;
        unique case (state_q)
            S_IDLE: begin
                step_d  = '0;
                page_d  = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: if (!db_q) state_d = S_WAIT_HI;
            S_WAIT_HI: if (db_q)  state_d = S_LOAD;
            S_LOAD: begin
                if (step_q == STEP_W'(NUM_LOADS - 1)) begin
                    ccnt_d  = '0;
                    state_d = S_COMPUTE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_WAIT_LO;
                end
            end
            S_COMPUTE: begin
                ccnt_d = ccnt_q + CC_W'(1);
                if (ccnt_q == CC_W'(COMPUTE_CYCLES - 1)) state_d = S_DISP_LO;
            end
            S_DISP_LO: if (!db_q) state_d = S_DISP_HI;
            S_DISP_HI: if (db_q)  state_d = S_DISP;
            S_DISP: begin
                if (!db_q) begin
                    if (page_q == PAGE_W'(NUM_DISP - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        page_d  = page_q + PAGE_W'(1);
                        state_d = S_DISP_HI;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.Clear) begin
            state_d = S_IDLE;
            step_d  = '0;
            page_d  = '0;
        end
    end

    // Outputs are decoded from the next state and registered so they align with state_q.
    always_comb begin
        load_en_d = '0;
        disp_en_d = '0;
        for (int i = 0; i < int'(NUM_LOADS); i++) begin
            load_en_d[i] = (state_d == S_LOAD) && (step_d == STEP_W'(i));
        end
        for (int i = 0; i < int'(NUM_DISP); i++) begin
            disp_en_d[i] = (state_d == S_DISP) && (page_d == PAGE_W'(i));
        end
        compute_d = (state_d == S_COMPUTE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            page_q    <= '0;
            ccnt_q    <= '0;
            load_en_q <= '0;
            disp_en_q <= '0;
            compute_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            page_q    <= page_d;
            ccnt_q    <= ccnt_d;
            load_en_q <= load_en_d;
            disp_en_q <= disp_en_d;
            compute_q <= compute_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.load_en  = load_en_q;
    assign bus.load_idx = step_q;
    assign bus.compute  = compute_q;
    assign bus.disp_en  = disp_en_q;
    assign bus.ready_db = db_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_butterfly_seq_ctrl.sv
// Bench for butterfly_seq_ctrl (3 loads, 2 pages, 2 compute cycles, debounce 4):
// ordered event scoreboard fed by a toggle table plus hand-written corner sequences.
module tb_butterfly_seq_ctrl;
    localparam int unsigned NL = 3;
    localparam int unsigned ND = 2;

    localparam logic [2:0] K_LOAD = 3'd0;
    localparam logic [2:0] K_COMP = 3'd1;
    localparam logic [2:0] K_DISP = 3'd2;
    localparam logic [2:0] K_DONE = 3'd3;
    localparam logic [2:0] K_IDLE = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] val;
    } ev_t;

    typedef struct {
        logic lvl;
        int   n_ev;
        ev_t  ev0;
        ev_t  ev1;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    butterfly_seq_ctrl_if #(.NUM_LOADS(NL), .NUM_DISP(ND)) bus ();

    butterfly_seq_ctrl #(
        .NUM_LOADS(NL), .NUM_DISP(ND), .COMPUTE_CYCLES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    int   total = 0;
    int   bad   = 0;
    ev_t  sb[$];
    bit   mon_on = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [2:0] k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    function automatic ev_t ld(input logic [1:0] idx, input logic [2:0] en);
        return mk(K_LOAD, 8'({idx, en}));
    endfunction

    task automatic got(input logic [2:0] k, input logic [7:0] v);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d val=%0h want=none", k, v);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL sb_event got kind=%0d val=%0h want kind=%0d val=%0h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: turn output activity into ordered events for the scoreboard.
    int            comp_run = 0;
    int            idle_run = 0;
    logic [ND-1:0] prev_disp = '0;
    always @(negedge clk) begin
        if (!mon_on) begin
            comp_run  = 0;
            idle_run  = 0;
            prev_disp = '0;
        end else begin
            if (bus.load_en != '0) got(K_LOAD, 8'({bus.load_idx, bus.load_en}));
            if (bus.compute) comp_run++;
            else if (comp_run != 0) begin
                got(K_COMP, 8'(comp_run));
                comp_run = 0;
            end
            if (bus.disp_en != prev_disp && bus.disp_en != '0) got(K_DISP, 8'(bus.disp_en));
            prev_disp = bus.disp_en;
            if (bus.done) got(K_DONE, 8'd1);
            if (!bus.busy) idle_run++;
            else if (idle_run != 0) begin
                got(K_IDLE, 8'(idle_run));
                idle_run = 0;
            end
        end
    end

    task automatic drive(input logic lvl, input int cycles);
        bus.ReadyIn = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.Clear = 1'b1;
        @(negedge clk);
        bus.Clear = 1'b0;
    endtask

    initial begin
        row_t rows[9];
        int   n;
        logic mx;
        logic [2:0] seen;
        bit   hit;

        rows[0] = '{1'b0, 0, '0, '0};
        rows[1] = '{1'b1, 1, ld(2'd1, 3'b010), '0};
        rows[2] = '{1'b0, 0, '0, '0};
        rows[3] = '{1'b1, 2, ld(2'd2, 3'b100), mk(K_COMP, 8'd2)};
        rows[4] = '{1'b0, 0, '0, '0};
        rows[5] = '{1'b1, 1, mk(K_DISP, 8'b01), '0};
        rows[6] = '{1'b0, 0, '0, '0};
        rows[7] = '{1'b1, 1, mk(K_DISP, 8'b10), '0};
        rows[8] = '{1'b0, 2, mk(K_DONE, 8'd1), mk(K_IDLE, 8'd1)};

        bus.ReadyIn = 1'b0;
        bus.Clear   = 1'b0;

        // Reset defaults
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_load_en", 32'(bus.load_en), 0);
        check("rst_disp_en", 32'(bus.disp_en), 0);
        check("rst_compute", 32'(bus.compute), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_load_idx", 32'(bus.load_idx), 0);
        check("rst_ready_db", 32'(bus.ready_db), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_release", 32'(bus.busy), 1);

        // Short glitch must be rejected
        mx = 1'b0;
        bus.ReadyIn = 1'b1;
        repeat (3) begin @(negedge clk); mx |= bus.ready_db; end
        bus.ReadyIn = 1'b0;
        repeat (12) begin @(negedge clk); mx |= bus.ready_db; end
        check("glitch_ready_db", 32'(mx), 0);

        // Clean edge latency, which also triggers the first load
        mon_on = 1'b1;
        sb.push_back(ld(2'd0, 3'b001));
        bus.ReadyIn = 1'b1;
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.ready_db) break;
        end
        check("db_latency", 32'(n), 6);
        repeat (6) @(negedge clk);

        // Table: remaining toggles of a full run
        for (int r = 0; r < 9; r++) begin
            if (rows[r].n_ev > 0) sb.push_back(rows[r].ev0);
            if (rows[r].n_ev > 1) sb.push_back(rows[r].ev1);
            drive(rows[r].lvl, 12);
        end
        check("run_sb_empty", 32'(sb.size()), 0);

        // Held switch: one load only, next load needs a fresh toggle
        sb.push_back(ld(2'd0, 3'b001));
        drive(1'b1, 100);
        check("held_single_load", 32'(sb.size()), 0);
        drive(1'b0, 12);
        sb.push_back(ld(2'd1, 3'b010));
        drive(1'b1, 12);

        // Clear out of WAIT_LO at step 2
        sb.push_back(mk(K_IDLE, 8'd1));
        pulse_clear();
        repeat (3) @(negedge clk);
        drive(1'b0, 12);
        sb.push_back(ld(2'd0, 3'b001));
        drive(1'b1, 12);
        drive(1'b0, 12);

        // Abort in WAIT_HI at step 1
        check("abort_pre_idx", 32'(bus.load_idx), 1);
        sb.push_back(mk(K_IDLE, 8'd1));
        pulse_clear();
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_idx", 32'(bus.load_idx), 0);
        sb.push_back(ld(2'd0, 3'b001));
        drive(1'b1, 12);
        check("abort_sb_empty", 32'(sb.size()), 0);

        // Async reset during compute
        mon_on = 1'b0;
        drive(1'b0, 12);
        drive(1'b1, 12);
        drive(1'b0, 12);
        bus.ReadyIn = 1'b1;
        seen = '0;
        hit  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.load_en != '0) seen = bus.load_en;
            if (bus.compute) begin hit = 1'b1; break; end
        end
        check("comp_reached", 32'(hit), 1);
        check("comp_last_load", 32'(seen), 4);
        #1 rst = 1'b1;
        #1;
        check("arst_compute", 32'(bus.compute), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_ready_db", 32'(bus.ready_db), 0);
        check("arst_load_idx", 32'(bus.load_idx), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mx = 1'b0;
        repeat (40) begin @(negedge clk); mx |= bus.done; end
        check("arst_no_done", 32'(mx), 0);
        check("arst_busy_after", 32'(bus.busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
